// File: rtl/proj_qsys_onchip_mem_arbiter.sv
// Shares the single-port 1024x32 on-chip RAM between the Nios II data master
// (A) and the display scan-out reader (B). Burst-limited round-robin keeps
// either side from starving the other; reads return one cycle after grant.
module proj_qsys_onchip_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam logic       OWN_A     = 1'b0;
    localparam logic       OWN_B     = 1'b1;
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    cmd_t       cmd_a, cmd_b, cmd_w;
    logic       req_a, req_b, grant_a, grant_b, grant, win;
    logic       last_owner, rd_pend, rd_owner;
    logic [7:0] burst_cnt;

    assign cmd_a = '{rd: a_read, wr: a_write, addr: a_address, be: a_byteenable, data: a_writedata};
    assign cmd_b = '{rd: b_read, wr: b_write, addr: b_address, be: b_byteenable, data: b_writedata};
    assign req_a = cmd_a.rd | cmd_a.wr;
    assign req_b = cmd_b.rd | cmd_b.wr;

    // Winner: a lone requester always wins; under contention the current
    // owner keeps the port until it has used up its burst allowance.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset_n) begin
            if (req_a && req_b) begin
                grant_b = (burst_cnt < BURST_LIM) ? (last_owner == OWN_B) : (last_owner == OWN_A);
                grant_a = ~grant_b;
            end else begin
                grant_a = req_a;
                grant_b = req_b;
            end
        end
    end

    assign grant = grant_a | grant_b;
    assign win   = grant_b ? OWN_B : OWN_A;
    assign cmd_w = grant_b ? cmd_b : cmd_a;

    // RAM command follows the winner; write wins over read when both are set
    assign mem_address    = cmd_w.addr;
    assign mem_byteenable = cmd_w.be;
    assign mem_writedata  = cmd_w.data;
    assign mem_chipselect = grant;
    assign mem_write      = grant & cmd_w.wr;
    assign mem_clken      = reset_n;

    assign a_waitrequest  = ~reset_n | (req_a & ~grant_a);
    assign b_waitrequest  = ~reset_n | (req_b & ~grant_b);

    // Ownership and burst accounting, updated only on cycles with a grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_A;
            burst_cnt  <= '0;
        end else if (grant) begin
            if (win == last_owner) begin
                burst_cnt <= (burst_cnt < BURST_LIM) ? burst_cnt + 8'd1 : BURST_LIM;
            end else begin
                last_owner <= win;
                burst_cnt  <= 8'd1;
            end
        end
    end

    // One-deep read tracker: RAM data comes back exactly one cycle after grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_A;
        end else begin
            rd_pend <= grant & cmd_w.rd & ~cmd_w.wr;
            if (grant & cmd_w.rd & ~cmd_w.wr)
                rd_owner <= win;
        end
    end

    assign a_readdatavalid = rd_pend & (rd_owner == OWN_A);
    assign b_readdatavalid = rd_pend & (rd_owner == OWN_B);
    assign a_readdata      = a_readdatavalid ? mem_readdata : '0;
    assign b_readdata      = b_readdatavalid ? mem_readdata : '0;
endmodule
